// File: rtl/conv_pe_acc.sv
// Convolution processing element: TAPS-wide signed multiply, registered adder tree and a
// cross-channel accumulator with bias preload, followed by optional ReLU and saturating requantisation.
module conv_pe_acc #(
   parameter int TAPS = 25,
   parameter int DW   = 8,
   parameter int ACCW = 32,
   parameter int OUTW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [TAPS*DW-1:0]   in_if,
   input  logic [TAPS*DW-1:0]   in_w,
   input  logic [ACCW-1:0]      bias,
   input  logic                 relu_en,
   input  logic                 quan_en,
   input  logic [4:0]           shift,
   output logic                 out_valid,
   output logic [ACCW-1:0]      out_data
);

   if ((ACCW < 2*DW + $clog2(TAPS) + 1) || (OUTW > ACCW)) begin : g_param_check
      $error("conv_pe_acc: ACCW too narrow for TAPS/DW, or OUTW wider than ACCW");
   end

   // Rounding adds up to 2^30 before the shift, so the quantiser works well above ACCW.
   localparam int EW = ACCW + 33;
   localparam logic signed [EW-1:0] Q_MAX = EW'((64'sd1 <<< (OUTW-1)) - 64'sd1);
   localparam logic signed [EW-1:0] Q_MIN = ~Q_MAX;

   logic signed [2*DW-1:0] mult [TAPS];

   for (genvar k = 0; k < TAPS; k++) begin : g_mult
      logic signed [2*DW-1:0] a;
      logic signed [2*DW-1:0] b;
      assign a       = (2*DW)'($signed(in_if[k*DW +: DW]));
      assign b       = (2*DW)'($signed(in_w[k*DW +: DW]));
      assign mult[k] = a * b;
   end

   logic                   s1_valid, s1_first, s1_last, s1_relu, s1_quan;
   logic [4:0]             s1_shift;
   logic signed [ACCW-1:0] s1_bias;
   logic signed [ACCW-1:0] s1_prod [TAPS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_relu  <= 1'b0;
         s1_quan  <= 1'b0;
         s1_shift <= '0;
         s1_bias  <= '0;
         for (int k = 0; k < TAPS; k++) s1_prod[k] <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_relu  <= relu_en;
            s1_quan  <= quan_en;
            s1_shift <= shift;
            s1_bias  <= $signed(bias);
            for (int k = 0; k < TAPS; k++) s1_prod[k] <= ACCW'(mult[k]);
         end
      end
   end

   logic signed [ACCW-1:0] sum_c;

   always_comb begin
      sum_c = '0;
      for (int k = 0; k < TAPS; k++) sum_c = sum_c + s1_prod[k];
   end

   logic                   s2_valid, s2_first, s2_last, s2_relu, s2_quan;
   logic [4:0]             s2_shift;
   logic signed [ACCW-1:0] s2_bias, s2_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_relu  <= 1'b0;
         s2_quan  <= 1'b0;
         s2_shift <= '0;
         s2_bias  <= '0;
         s2_sum   <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_relu  <= s1_relu;
            s2_quan  <= s1_quan;
            s2_shift <= s1_shift;
            s2_bias  <= s1_bias;
            s2_sum   <= sum_c;
         end
      end
   end

   logic signed [ACCW-1:0] acc, acc_next, relu_val, post_c;
   logic signed [EW-1:0]   r_ext, half, q_ext;
   logic signed [OUTW-1:0] q_sat;

   // Round-half-up is folded in as +2^(shift-1) ahead of the arithmetic shift.
   always_comb begin
      acc_next = (s2_first ? s2_bias : acc) + s2_sum;
      relu_val = (s2_relu && (acc_next < 0)) ? '0 : acc_next;
      r_ext    = EW'(relu_val);
      half     = '0;
      if (s2_shift != 5'd0) half = EW'(1) <<< (s2_shift - 5'd1);
      q_ext    = (r_ext + half) >>> s2_shift;
      if (q_ext > Q_MAX)      q_sat = Q_MAX[OUTW-1:0];
      else if (q_ext < Q_MIN) q_sat = Q_MIN[OUTW-1:0];
      else                    q_sat = q_ext[OUTW-1:0];
      post_c   = s2_quan ? ACCW'(q_sat) : relu_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= s2_valid && s2_last;
         if (s2_valid) begin
            acc <= acc_next;
            if (s2_last) out_data <= post_c;
         end
      end
   end

endmodule

// File: tb/tb_conv_pe_acc.sv
// Directed bench for conv_pe_acc: table of single-pass pixels plus hand-written
// multi-pass, bubble, reset and streaming sequences; pulses are captured by a negedge monitor.
module tb_conv_pe_acc;

   localparam int TAPS = 25;
   localparam int DW   = 8;
   localparam int ACCW = 32;
   localparam int OUTW = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid, in_first, in_last;
   logic [TAPS*DW-1:0]   in_if, in_w;
   logic [ACCW-1:0]      bias;
   logic                 relu_en, quan_en;
   logic [4:0]           shift;
   logic                 out_valid;
   logic [ACCW-1:0]      out_data;

   conv_pe_acc #(.TAPS(TAPS), .DW(DW), .ACCW(ACCW), .OUTW(OUTW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .in_if(in_if), .in_w(in_w), .bias(bias), .relu_en(relu_en), .quan_en(quan_en),
      .shift(shift), .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                     cyc;
      logic signed [ACCW-1:0] data;
   } ev_t;
   ev_t evq[$];

   always @(negedge clk) begin
      if (out_valid === 1'b1) evq.push_back('{cyc, $signed(out_data)});
   end

   typedef struct {
      logic signed [DW-1:0]   ifv;
      logic signed [DW-1:0]   wv;
      logic signed [ACCW-1:0] b;
      logic                   relu;
      logic                   quan;
      logic [4:0]             sh;
      logic signed [ACCW-1:0] exp;
   } vec_t;
   vec_t vecs[11];

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives one beat starting at a negedge; returns the cycle count after the sampling edge.
   task automatic applyStimulus(input logic signed [DW-1:0] ifv, input logic signed [DW-1:0] wv,
                                input logic signed [ACCW-1:0] b, input logic first, input logic last,
                                input logic relu, input logic quan, input logic [4:0] sh,
                                output int edge_cyc);
      in_valid = 1'b1;
      in_first = first;
      in_last  = last;
      in_if    = {TAPS{ifv}};
      in_w     = {TAPS{wv}};
      bias     = b;
      relu_en  = relu;
      quan_en  = quan;
      shift    = sh;
      @(negedge clk);
      edge_cyc = cyc;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkPixel(input string name, input int last_cyc, input logic signed [ACCW-1:0] exp);
      checkOutput({name, " pulses"}, evq.size(), 1);
      if (evq.size() >= 1) begin
         checkOutput({name, " latency"}, evq[0].cyc, last_cyc + 2);
         checkOutput({name, " data"}, evq[0].data, exp);
      end
      evq.delete();
   endtask

   int e0, e1, e2;
   int starts[8];

   initial begin
      vecs[0]  = '{8'sd1,    8'sd1,   32'sd0,   1'b0, 1'b0, 5'd0, 32'sd25};
      vecs[1]  = '{-8'sd128, 8'sd127, 32'sd0,   1'b0, 1'b0, 5'd0, -32'sd406400};
      vecs[2]  = '{-8'sd128, 8'sd127, 32'sd0,   1'b1, 1'b0, 5'd0, 32'sd0};
      vecs[3]  = '{8'sd8,    8'sd2,   32'sd64,  1'b0, 1'b1, 5'd7, 32'sd4};
      vecs[4]  = '{8'sd127,  8'sd127, 32'sd0,   1'b0, 1'b1, 5'd7, 32'sd127};
      vecs[5]  = '{-8'sd128, 8'sd127, 32'sd0,   1'b0, 1'b1, 5'd7, -32'sd128};
      vecs[6]  = '{8'sd1,    8'sd1,   32'sd0,   1'b0, 1'b1, 5'd0, 32'sd25};
      vecs[7]  = '{-8'sd128, 8'sd127, 32'sd0,   1'b1, 1'b1, 5'd7, 32'sd0};
      vecs[8]  = '{8'sd0,    8'sd0,   -32'sd5,  1'b0, 1'b0, 5'd0, -32'sd5};
      vecs[9]  = '{8'sd0,    8'sd0,   -32'sd3,  1'b0, 1'b1, 5'd1, -32'sd1};
      vecs[10] = '{8'sd0,    8'sd0,   32'sd5,   1'b0, 1'b1, 5'd1, 32'sd3};

      rst = 1'b1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      in_if = '0; in_w = '0; bias = '0;
      relu_en = 1'b0; quan_en = 1'b0; shift = '0;
      #1;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_data", out_data, 0);
      idle(2);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 11; i++) begin
         evq.delete();
         applyStimulus(vecs[i].ifv, vecs[i].wv, vecs[i].b, 1'b1, 1'b1,
                       vecs[i].relu, vecs[i].quan, vecs[i].sh, e0);
         idle(5);
         checkPixel($sformatf("vec%0d", i), e0, vecs[i].exp);
      end

      // Back-to-back three-pass pixel; controls on non-last beats must not matter.
      applyStimulus(8'sd2, 8'sd3, 32'sd10, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, e0);
      applyStimulus(8'sd2, 8'sd3, 32'sd999, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, e1);
      applyStimulus(8'sd2, 8'sd3, 32'sd999, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, e2);
      idle(5);
      checkPixel("multipass", e2, 32'sd460);

      applyStimulus(8'sd2, 8'sd3, 32'sd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, e0);
      idle(2);
      applyStimulus(8'sd2, 8'sd3, 32'sd10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, e1);
      idle(2);
      applyStimulus(8'sd2, 8'sd3, 32'sd10, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, e2);
      idle(5);
      checkPixel("bubbles", e2, 32'sd460);
      checkOutput("hold out_data", $signed(out_data), 460);

      // Last without first keeps accumulating onto 460.
      applyStimulus(8'sd1, 8'sd1, 32'sd777, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, e0);
      idle(5);
      checkPixel("no-first", e0, 32'sd485);

      applyStimulus(8'sd5, 8'sd5, 32'sd100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, e0);
      rst = 1'b1;
      #1;
      checkOutput("midreset out_valid", out_valid, 0);
      checkOutput("midreset out_data", out_data, 0);
      idle(3);
      rst = 1'b0;
      idle(2);
      checkOutput("post-reset no pulse", evq.size(), 0);
      evq.delete();
      applyStimulus(8'sd1, 8'sd1, 32'sd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, e0);
      idle(5);
      checkPixel("post-reset acc", e0, 32'sd25);
      applyStimulus(8'sd1, 8'sd1, 32'sd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, e0);
      idle(5);
      checkPixel("post-reset single", e0, 32'sd25);

      for (int n = 1; n <= 8; n++)
         applyStimulus(DW'(n), 8'sd1, 32'sd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, starts[n-1]);
      idle(6);
      checkOutput("stream pulses", evq.size(), 8);
      for (int n = 1; n <= 8; n++) begin
         if (evq.size() >= n) begin
            checkOutput($sformatf("stream%0d latency", n), evq[n-1].cyc, starts[n-1] + 2);
            checkOutput($sformatf("stream%0d data", n), evq[n-1].data, 25 * n);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
